// File: rtl/mem_arbiter_2to1.sv
// mem_arbiter_2to1: shares one native memory port between two requesters.
// Requester 0 is the CPU core, requester 1 is a loader/debug/DMA master.
// The grant is locked for the whole transaction. Selection is round-robin
// or fixed-priority. A watchdog force-completes a transfer that the
// downstream memory never acknowledges.
module mem_arbiter_2to1 #(
    parameter bit          FIXED_PRIO     = 1'b0,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [1:0]  req_instr,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_wstrb,
    output logic [31:0] req_rdata,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic        mem_instr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    output logic [1:0]  grant,
    output logic        timeout_err
);

    // The counter only has to reach TIMEOUT_CYCLES-1.
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit WD_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       grant_q, grant_d;
    logic             rr_last_q, rr_last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_err_q, timeout_err_d;

    // Per-requester views of the packed request buses.
    logic [31:0] addr_arr  [2];
    logic [31:0] wdata_arr [2];
    logic [3:0]  wstrb_arr [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_split
            assign addr_arr[gi]  = req_addr[32*gi +: 32];
            assign wdata_arr[gi] = req_wdata[32*gi +: 32];
            assign wstrb_arr[gi] = req_wstrb[4*gi +: 4];
        end
    endgenerate

    logic owner_idx;
    logic owner_valid;
    logic busy;
    logic timeout_hit;
    logic done;
    logic pick_idx;

    // The grant is one-hot, so its upper bit is the owner index.
    assign owner_idx   = grant_q[1];
    assign owner_valid = req_valid[owner_idx];
    // Reset suppresses all outputs at once, so a reset during BUSY never
    // produces a completion pulse.
    assign busy        = (state_q == ST_BUSY) && !reset;
    // mem_ready in the last watchdog cycle takes precedence over the timeout.
    assign timeout_hit = WD_EN && busy && owner_valid && !mem_ready && (cnt_q == CNT_MAX);
    assign done        = busy && owner_valid && (mem_ready || timeout_hit);

    // Arbitration choice used when leaving IDLE.
    always_comb begin
        pick_idx = 1'b0;
        if (req_valid == 2'b11) begin
            pick_idx = FIXED_PRIO ? 1'b0 : ~rr_last_q;
        end else if (req_valid[1]) begin
            pick_idx = 1'b1;
        end
    end

    // Combinational pass-through from the owner while BUSY. Everything is zero otherwise.
    always_comb begin
        mem_valid = 1'b0;
        mem_instr = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        mem_wstrb = 4'h0;
        req_ready = 2'b00;
        req_rdata = 32'h0;
        if (busy) begin
            mem_valid = owner_valid && !timeout_hit;
            mem_instr = req_instr[owner_idx];
            mem_addr  = addr_arr[owner_idx];
            mem_wdata = wdata_arr[owner_idx];
            mem_wstrb = wstrb_arr[owner_idx];
            if (done) begin
                req_ready = grant_q;
                req_rdata = mem_ready ? mem_rdata : 32'hFFFF_FFFF;
            end
        end
    end

    // Next-state logic for the IDLE/BUSY controller, grant, round-robin pointer and watchdog.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        rr_last_d     = rr_last_q;
        cnt_d         = cnt_q;
        timeout_err_d = timeout_err_q;
        case (state_q)
            ST_IDLE: begin
                if (|req_valid) begin
                    state_d = ST_BUSY;
                    grant_d = pick_idx ? 2'b10 : 2'b01;
                    cnt_d   = '0;
                end
            end
            ST_BUSY: begin
                if (!owner_valid) begin
                    // Owner withdrew: abandon without touching the fairness pointer.
                    state_d = ST_IDLE;
                    grant_d = 2'b00;
                end else if (mem_ready) begin
                    state_d   = ST_IDLE;
                    grant_d   = 2'b00;
                    rr_last_d = owner_idx;
                end else if (timeout_hit) begin
                    state_d       = ST_IDLE;
                    grant_d       = 2'b00;
                    rr_last_d     = owner_idx;
                    timeout_err_d = 1'b1;
                end else if (WD_EN) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    // State register with synchronous reset. rr_last starts at 1 so that requester 0 wins first.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            grant_q       <= 2'b00;
            rr_last_q     <= 1'b1;
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            rr_last_q     <= rr_last_d;
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign grant       = grant_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mem_arbiter_2to1.sv
// Directed testbench for mem_arbiter_2to1. Two instances share the stimulus:
// dut_a is round-robin and dut_b is fixed-priority. Both use an 8-cycle watchdog.
module tb_mem_arbiter_2to1;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_instr;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    logic [1:0]  req_ready_a, req_ready_b;
    logic [31:0] req_rdata_a, req_rdata_b;
    logic        mem_valid_a, mem_valid_b;
    logic        mem_instr_a, mem_instr_b;
    logic [31:0] mem_addr_a, mem_addr_b;
    logic [31:0] mem_wdata_a, mem_wdata_b;
    logic [3:0]  mem_wstrb_a, mem_wstrb_b;
    logic [1:0]  grant_a, grant_b;
    logic        timeout_err_a, timeout_err_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_arbiter_2to1 #(.FIXED_PRIO(1'b0), .TIMEOUT_CYCLES(8)) dut_a (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready_a), .req_instr(req_instr),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .req_rdata(req_rdata_a),
        .mem_valid(mem_valid_a), .mem_ready(mem_ready), .mem_instr(mem_instr_a),
        .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .mem_wstrb(mem_wstrb_a),
        .mem_rdata(mem_rdata), .grant(grant_a), .timeout_err(timeout_err_a)
    );

    mem_arbiter_2to1 #(.FIXED_PRIO(1'b1), .TIMEOUT_CYCLES(8)) dut_b (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready_b), .req_instr(req_instr),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .req_rdata(req_rdata_b),
        .mem_valid(mem_valid_b), .mem_ready(mem_ready), .mem_instr(mem_instr_b),
        .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_wstrb(mem_wstrb_b),
        .mem_rdata(mem_rdata), .grant(grant_b), .timeout_err(timeout_err_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and step 1 time unit past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = 2'b00;
        mem_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    logic [1:0] exp_rr [4];
    int na0, na1, nb0;

    initial begin
        exp_rr[0] = 2'b01; exp_rr[1] = 2'b10; exp_rr[2] = 2'b01; exp_rr[3] = 2'b10;
        req_instr = 2'b00;
        req_addr  = 64'h0;
        req_wdata = 64'h0;
        req_wstrb = 8'h0;
        mem_rdata = 32'h0;
        do_reset();
        chk("reset_grant", grant_a, 2'b00);
        chk("reset_mem_valid", mem_valid_a, 1'b0);
        chk("reset_timeout_err", timeout_err_a, 1'b0);
        chk("reset_req_ready", req_ready_a, 2'b00);
        $display("reset done");

        // Single read from requester 0. The memory responds in the third BUSY cycle.
        req_addr  = {32'h0, 32'h0000_0100};
        req_valid = 2'b01;
        #1;
        chk("rd_arb_latency_mem_valid", mem_valid_a, 1'b0);
        tick();
        chk("rd_c1_mem_valid", mem_valid_a, 1'b1);
        chk("rd_c1_mem_addr", mem_addr_a, 32'h100);
        chk("rd_c1_grant", grant_a, 2'b01);
        chk("rd_c1_req_ready", req_ready_a, 2'b00);
        tick();
        tick();
        mem_ready = 1'b1;
        mem_rdata = 32'h1234_5678;
        #1;
        chk("rd_c3_req_ready", req_ready_a, 2'b01);
        chk("rd_c3_req_rdata", req_rdata_a, 32'h1234_5678);
        tick();
        req_valid = 2'b00;
        mem_ready = 1'b0;
        #1;
        chk("rd_after_grant", grant_a, 2'b00);
        chk("rd_after_req_ready", req_ready_a, 2'b00);
        $display("single read: rdata=%h", 32'h1234_5678);

        // Contention. dut_a alternates between requesters; dut_b always serves requester 0.
        do_reset();
        req_addr = {32'h0000_2000, 32'h0000_1000};
        na0 = 0; na1 = 0; nb0 = 0;
        for (int t = 0; t < 4; t++) begin
            req_valid = 2'b11;
            mem_ready = 1'b0;
            #1;
            chk("rr_idle_grant", grant_a, 2'b00);
            tick();
            chk("rr_grant_a", grant_a, exp_rr[t]);
            chk("fp_grant_b", grant_b, 2'b01);
            chk("rr_mem_addr_a", mem_addr_a, (exp_rr[t] == 2'b01) ? 32'h1000 : 32'h2000);
            tick();
            mem_ready = 1'b1;
            mem_rdata = 32'hA0 + t;
            #1;
            chk("rr_req_ready_a", req_ready_a, exp_rr[t]);
            chk("fp_req_ready_b", req_ready_b, 2'b01);
            if (req_ready_a[0]) na0++;
            if (req_ready_a[1]) na1++;
            if (req_ready_b[0]) nb0++;
            tick();
            mem_ready = 1'b0;
            $display("contention transfer %0d: grant_a=%b grant_b=%b", t, req_ready_a, req_ready_b);
        end
        chk("rr_count_req0", na0, 2);
        chk("rr_count_req1", na1, 2);
        chk("fp_count_req0", nb0, 4);
        // Fixed priority lets requester 1 in once requester 0 drops.
        req_valid = 2'b10;
        #1;
        tick();
        chk("fp_req1_grant_b", grant_b, 2'b10);
        tick();
        mem_ready = 1'b1;
        #1;
        chk("fp_req1_ready_b", req_ready_b, 2'b10);
        tick();
        req_valid = 2'b00;
        mem_ready = 1'b0;
        $display("fixed priority: req1 served after req0 dropped");

        // Write mux from requester 1.
        req_addr  = {32'h2000_0000, 32'h0000_0000};
        req_wdata = {32'hCAFE_F00D, 32'h1111_1111};
        req_wstrb = 8'hF0;
        req_valid = 2'b10;
        #1;
        tick();
        chk("wr_grant", grant_a, 2'b10);
        chk("wr_mem_addr", mem_addr_a, 32'h2000_0000);
        chk("wr_mem_wdata", mem_wdata_a, 32'hCAFE_F00D);
        chk("wr_mem_wstrb", mem_wstrb_a, 4'hF);
        chk("wr_mem_valid", mem_valid_a, 1'b1);
        mem_ready = 1'b1;
        #1;
        chk("wr_req_ready", req_ready_a, 2'b10);
        tick();
        req_valid = 2'b00;
        mem_ready = 1'b0;
        req_wstrb = 8'h00;
        $display("write: addr=%h wdata=%h", 32'h2000_0000, 32'hCAFE_F00D);

        // mem_ready in the last watchdog cycle wins over the timeout.
        do_reset();
        req_addr  = {32'h0, 32'h0000_0300};
        req_valid = 2'b01;
        #1;
        tick();
        repeat (6) tick();
        chk("wd_ready_c7_req_ready", req_ready_a, 2'b00);
        chk("wd_ready_c7_mem_valid", mem_valid_a, 1'b1);
        tick();
        mem_ready = 1'b1;
        mem_rdata = 32'h5A5A_5A5A;
        #1;
        chk("wd_ready_c8_req_ready", req_ready_a, 2'b01);
        chk("wd_ready_c8_rdata", req_rdata_a, 32'h5A5A_5A5A);
        chk("wd_ready_c8_mem_valid", mem_valid_a, 1'b1);
        tick();
        req_valid = 2'b00;
        mem_ready = 1'b0;
        #1;
        chk("wd_ready_no_err", timeout_err_a, 1'b0);
        $display("late ready at watchdog limit: normal completion");

        // Real timeout: no mem_ready at all.
        req_valid = 2'b01;
        #1;
        tick();
        repeat (6) tick();
        chk("to_c7_req_ready", req_ready_a, 2'b00);
        chk("to_c7_mem_valid", mem_valid_a, 1'b1);
        tick();
        chk("to_c8_req_ready", req_ready_a, 2'b01);
        chk("to_c8_rdata", req_rdata_a, 32'hFFFF_FFFF);
        chk("to_c8_mem_valid", mem_valid_a, 1'b0);
        chk("to_c8_err_not_yet", timeout_err_a, 1'b0);
        tick();
        req_valid = 2'b00;
        #1;
        chk("to_err_set", timeout_err_a, 1'b1);
        chk("to_grant_idle", grant_a, 2'b00);
        req_addr  = {32'h0000_0400, 32'h0000_0300};
        req_valid = 2'b10;
        #1;
        tick();
        chk("to_next_grant", grant_a, 2'b10);
        mem_ready = 1'b1;
        mem_rdata = 32'h0BAD_BEEF;
        #1;
        chk("to_next_ready", req_ready_a, 2'b10);
        chk("to_next_rdata", req_rdata_a, 32'h0BAD_BEEF);
        tick();
        req_valid = 2'b00;
        mem_ready = 1'b0;
        #1;
        chk("to_err_sticky", timeout_err_a, 1'b1);
        $display("timeout: rdata=%h err=%b", 32'hFFFF_FFFF, timeout_err_a);

        // Reset during BUSY.
        req_valid = 2'b01;
        #1;
        tick();
        chk("rst_busy_mem_valid", mem_valid_a, 1'b1);
        reset     = 1'b1;
        mem_ready = 1'b1;
        #1;
        chk("rst_busy_no_ready", req_ready_a, 2'b00);
        tick();
        reset     = 1'b0;
        mem_ready = 1'b0;
        #1;
        chk("rst_after_grant", grant_a, 2'b00);
        chk("rst_after_mem_valid", mem_valid_a, 1'b0);
        chk("rst_after_err_clear", timeout_err_a, 1'b0);
        req_valid = 2'b00;
        tick();
        $display("reset mid-busy: returned to idle");

        // Owner withdraws during BUSY. The round-robin pointer must stay unchanged.
        req_valid = 2'b01;
        #1;
        tick();
        chk("wd_busy_grant", grant_a, 2'b01);
        req_valid = 2'b00;
        mem_ready = 1'b1;
        #1;
        chk("wd_drop_mem_valid", mem_valid_a, 1'b0);
        chk("wd_drop_no_ready", req_ready_a, 2'b00);
        tick();
        mem_ready = 1'b0;
        #1;
        chk("wd_after_grant", grant_a, 2'b00);
        req_valid = 2'b11;
        #1;
        tick();
        chk("wd_rr_unchanged_grant", grant_a, 2'b01);
        mem_ready = 1'b1;
        #1;
        chk("wd_rr_ready", req_ready_a, 2'b01);
        tick();
        req_valid = 2'b00;
        mem_ready = 1'b0;
        $display("withdraw: idle next cycle, req0 still first");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter_2to1.md
Name: mem_arbiter_2to1

Overview:
- Shares one picorv32-style native memory port between two requesters: req 0 (CPU core) and req 1 (loader / debug / DMA master).
- Sits between the requesters and the native-to-AXI adapter that drives the AXI4-lite test memory.
- Per-transaction grant lock; round-robin or fixed-priority selection; watchdog on a stalled downstream.

Parameters:
FIXED_PRIO, 0, 0 = round-robin; 1 = req 0 always wins on contention
TIMEOUT_CYCLES, 1024, BUSY cycles without mem_ready before forced completion; 0 disables the watchdog

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
req_valid  in  2  bit i = request from requester i
req_ready  out  2  one-cycle completion pulse, bit i
req_instr  in  2  bit i = instruction fetch
req_addr  in  64  requester i at [32i+31:32i]
req_wdata  in  64  requester i at [32i+31:32i]
req_wstrb  in  8  requester i at [4i+3:4i]; 0 = read
req_rdata  out  32  read data, shared, valid only with req_ready
mem_valid  out  1  downstream request
mem_ready  in  1  downstream completion
mem_instr  out  1  muxed instr flag
mem_addr  out  32  muxed address
mem_wdata  out  32  muxed write data
mem_wstrb  out  4  muxed strobes
mem_rdata  in  32  downstream read data
grant  out  2  one-hot owner; 0 when idle
timeout_err  out  1  sticky watchdog flag

Behaviour:
- FSM states: IDLE, BUSY. All state is registered on posedge clk.
- Reset values: state IDLE, grant 0, rr_last 1 (req 0 wins first), timeout counter 0, timeout_err 0.
- IDLE, arbitration:
  - Any req_valid: pick owner, load one-hot grant, go BUSY. mem_valid rises the next cycle (1-cycle arbitration latency).
  - Both valid: FIXED_PRIO=1 picks req 0. FIXED_PRIO=0 picks the requester other than rr_last.
  - One valid: that one wins.
- BUSY, pass-through:
  - mem_valid = req_valid[g]. mem_instr/addr/wdata/wstrb are combinationally muxed from owner g.
  - Requesters hold their fields stable while valid, per the native protocol.
- BUSY & mem_ready: same cycle req_ready[g]=1 and req_rdata=mem_rdata. Next cycle: rr_last<=g, grant<=0, state IDLE.
- Throughput: minimum 2 cycles per transfer plus memory latency, with an IDLE gap between transfers.
- BUSY & !req_valid[g] (owner withdrew): mem_valid drops immediately, no req_ready, return to IDLE, rr_last unchanged.
- Watchdog (TIMEOUT_CYCLES>0):
  - Counter clears on entering BUSY and increments each BUSY cycle without mem_ready.
  - At count == TIMEOUT_CYCLES-1 with no mem_ready: req_ready[g]=1, req_rdata=32'hFFFF_FFFF, mem_valid forced 0 that cycle, timeout_err<=1, go IDLE.
  - mem_ready in that same cycle wins: normal completion, no error.
- Outside BUSY: mem_valid, mem_* outputs, req_ready and req_rdata are all 0. mem_ready in IDLE is ignored.
- The non-owner's req_valid is ignored until the next IDLE; its ready stays 0.
- timeout_err clears only on reset.
- Reset mid-BUSY: next cycle IDLE with reset values; the in-flight downstream access is abandoned and no req_ready is issued.

Test Plan:
- Single read: req0 valid, addr 0x100, wstrb 0; memory returns 0x12345678 after 3 cycles -> mem_valid at cycle 1, mem_addr 0x100, req_ready[0] pulse with req_rdata 0x12345678; no req_ready[1].
- Contention, round-robin: both valid continuously, FIXED_PRIO=0, mem_ready 1 cycle after mem_valid -> grants 0,1,0,1; each requester gets exactly 2 completions in 4 transfers.
- Contention, FIXED_PRIO=1: both valid -> req 0 served every transfer; req 1 served only after req0_valid drops.
- Write mux: req1 writes 0xCAFEF00D to 0x2000_0000 with wstrb 4'b1111 while req0 idle -> mem_wdata/mem_wstrb/mem_addr match, grant 2'b10 during BUSY.
- Timeout: TIMEOUT_CYCLES=8, mem_ready never asserted -> req_ready[g] pulses at the 8th BUSY cycle with req_rdata 0xFFFFFFFF, timeout_err 1 and stays 1; next request arbitrates normally.
- Reset mid-BUSY, and owner withdrawing valid mid-BUSY -> IDLE next cycle, grant 0, mem_valid 0, no req_ready pulse.
